// File: rtl/booth_acc_pkg.sv
// booth_acc_pkg: widths, FSM states and operand helpers for booth_pp_accumulator
package booth_acc_pkg;
    localparam int PP_W    = 34;
    localparam int PROD_W  = 64;
    localparam int N_PP    = 17;
    localparam int GROUP   = 4;
    localparam int N_STEPS = 5;

    typedef enum logic [2:0] {IDLE, COMPRESS, ADD, ADD_LO, ADD_HI, DONE} acc_state_t;

    // Correction bit i lands at weight 2^(2i); positions never overlap, so this is a pure interleave
    function automatic logic [PROD_W-1:0] corr_vec(input logic [N_PP-2:0] ec);
        logic [PROD_W-1:0] v;
        v = '0;
        for (int i = 0; i < N_PP - 1; i++) v[2*i] = ec[i];
        return v;
    endfunction

    function automatic logic [PROD_W-1:0] pp_term(input logic [PP_W-1:0] pp, input logic [3:0] idx);
        return {{(PROD_W-PP_W){pp[PP_W-1]}}, pp} << {idx, 1'b0};
    endfunction
endpackage

// File: rtl/booth_pp_accumulator_csa_6to2.sv
// csa_6to2: combinational 64-bit 6:2 carry-save compressor from four cascaded 3:2 stages
module csa_6to2
    import booth_acc_pkg::*;
(
    input  logic [PROD_W-1:0] a,
    input  logic [PROD_W-1:0] b,
    input  logic [PROD_W-1:0] c,
    input  logic [PROD_W-1:0] d,
    input  logic [PROD_W-1:0] e,
    input  logic [PROD_W-1:0] f,
    output logic [PROD_W-1:0] sum,
    output logic [PROD_W-1:0] carry
);
    logic [PROD_W-1:0] s1, c1, s2, c2, s3, c3;
    // carries move up one bit; anything past bit 63 falls off
    always_comb begin
        s1    = a ^ b ^ c;
        c1    = ((a & b) | (a & c) | (b & c)) << 1;
        s2    = d ^ e ^ f;
        c2    = ((d & e) | (d & f) | (e & f)) << 1;
        s3    = s1 ^ c1 ^ s2;
        c3    = ((s1 & c1) | (s1 & s2) | (c1 & s2)) << 1;
        sum   = s3 ^ c3 ^ c2;
        carry = ((s3 & c3) | (s3 & c2) | (c3 & c2)) << 1;
    end
endmodule

// File: rtl/booth_pp_accumulator.sv
// booth_pp_accumulator: sequential carry-save reduction of 17 Booth partial products into a 64-bit product.
// Define BOOTH_ACC_SPLIT_CPA_EN to split the final add into two 32-bit halves (one extra cycle).
module booth_pp_accumulator
    import booth_acc_pkg::*;
(
    input  logic              Clk,
    input  logic              Reset,
    input  logic              In_Valid,
    output logic              In_Ready,
    input  logic [PP_W-1:0]   PP0,
    input  logic [PP_W-1:0]   PP1,
    input  logic [PP_W-1:0]   PP2,
    input  logic [PP_W-1:0]   PP3,
    input  logic [PP_W-1:0]   PP4,
    input  logic [PP_W-1:0]   PP5,
    input  logic [PP_W-1:0]   PP6,
    input  logic [PP_W-1:0]   PP7,
    input  logic [PP_W-1:0]   PP8,
    input  logic [PP_W-1:0]   PP9,
    input  logic [PP_W-1:0]   PP10,
    input  logic [PP_W-1:0]   PP11,
    input  logic [PP_W-1:0]   PP12,
    input  logic [PP_W-1:0]   PP13,
    input  logic [PP_W-1:0]   PP14,
    input  logic [PP_W-1:0]   PP15,
    input  logic [31:0]       PP16,
    input  logic [15:0]       Error_Correction,
    output logic              Out_Valid,
    input  logic              Out_Ready,
    output logic [PROD_W-1:0] Product,
    output logic              Busy
);
`ifdef BOOTH_ACC_SPLIT_CPA_EN
    localparam acc_state_t FIRST_ADD = ADD_LO;
    logic cy;
`else
    localparam acc_state_t FIRST_ADD = ADD;
`endif

    acc_state_t        state;
    logic [2:0]        step;
    logic [PROD_W-1:0] s, c, csa_s, csa_c;
    logic [PROD_W-1:0] ops [GROUP];
    logic [PP_W-1:0]   pp_in [16];
    logic [PP_W-1:0]   pp_q [16];
    logic [31:0]       pp16_q;
    logic [15:0]       ec_q;

    assign pp_in    = '{PP0, PP1, PP2, PP3, PP4, PP5, PP6, PP7,
                        PP8, PP9, PP10, PP11, PP12, PP13, PP14, PP15};
    assign In_Ready = state == IDLE && !Reset;
    assign Busy     = state != IDLE;

    // Steps 0..3 take four aligned Booth rows; the last step folds in PP16 and the correction vector
    always_comb begin
        for (int k = 0; k < GROUP; k++) ops[k] = pp_term(pp_q[{step[1:0], 2'(k)}], {step[1:0], 2'(k)});
        if (step == 3'(N_STEPS - 1)) begin
            ops[0] = {pp16_q, 32'b0};
            ops[1] = corr_vec(ec_q);
            ops[2] = '0;
            ops[3] = '0;
        end
    end

    csa_6to2 u_csa (
        .a(s), .b(c), .c(ops[0]), .d(ops[1]), .e(ops[2]), .f(ops[3]),
        .sum(csa_s), .carry(csa_c)
    );

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state     <= IDLE;
            step      <= '0;
            s         <= '0;
            c         <= '0;
            Out_Valid <= 1'b0;
            Product   <= '0;
`ifdef BOOTH_ACC_SPLIT_CPA_EN
            cy        <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: if (In_Valid) begin
                    pp_q   <= pp_in;
                    pp16_q <= PP16;
                    ec_q   <= Error_Correction;
                    s      <= '0;
                    c      <= '0;
                    step   <= '0;
                    state  <= COMPRESS;
                end
                COMPRESS: begin
                    s     <= csa_s;
                    c     <= csa_c;
                    step  <= step + 3'd1;
                    state <= step == 3'(N_STEPS - 1) ? FIRST_ADD : COMPRESS;
                end
`ifdef BOOTH_ACC_SPLIT_CPA_EN
                ADD_LO: begin
                    {cy, Product[31:0]} <= {1'b0, s[31:0]} + {1'b0, c[31:0]};
                    state <= ADD_HI;
                end
                ADD_HI: begin
                    Product[63:32] <= s[63:32] + c[63:32] + {31'b0, cy};
                    Out_Valid      <= 1'b1;
                    state          <= DONE;
                end
`else
                ADD: begin
                    Product   <= s + c;
                    Out_Valid <= 1'b1;
                    state     <= DONE;
                end
`endif
                DONE: if (Out_Ready) begin
                    Out_Valid <= 1'b0;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_booth_pp_accumulator.sv
// tb_booth_pp_accumulator: scoreboard bench; Booth rows built from operands, results checked against a*b
module tb_booth_pp_accumulator;
`ifdef BOOTH_ACC_SPLIT_CPA_EN
    localparam int LAT = 7;
`else
    localparam int LAT = 6;
`endif
    logic        clk = 0;
    logic        Reset = 1;
    logic        In_Valid = 0;
    logic        In_Ready;
    logic [33:0] pp [16];
    logic [31:0] pp16 = '0;
    logic [15:0] ec = '0;
    logic        Out_Valid;
    logic        Out_Ready = 1;
    logic [63:0] Product;
    logic        Busy;

    int          n_cmp = 0, n_bad = 0, cyc = 0, mode = 0;
    bit          ov_prev = 0;
    logic [63:0] exp_q [$];
    int          acc_q [$];
    logic [63:0] held;

    booth_pp_accumulator dut (
        .Clk(clk), .Reset(Reset), .In_Valid(In_Valid), .In_Ready(In_Ready),
        .PP0(pp[0]), .PP1(pp[1]), .PP2(pp[2]), .PP3(pp[3]),
        .PP4(pp[4]), .PP5(pp[5]), .PP6(pp[6]), .PP7(pp[7]),
        .PP8(pp[8]), .PP9(pp[9]), .PP10(pp[10]), .PP11(pp[11]),
        .PP12(pp[12]), .PP13(pp[13]), .PP14(pp[14]), .PP15(pp[15]),
        .PP16(pp16), .Error_Correction(ec),
        .Out_Valid(Out_Valid), .Out_Ready(Out_Ready), .Product(Product), .Busy(Busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    // mode 0: ready high, 1: ready low, 2: random backpressure
    always @(negedge clk) Out_Ready = mode == 2 ? ($urandom_range(3) != 0) : (mode == 0);

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, want, cyc);
        end
    endtask

    task automatic fail(input string name);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: event not as required (cycle %0d)", name, cyc);
    endtask

    function automatic logic [63:0] ref_prod(input logic [31:0] a, input logic [31:0] b, input bit sgn);
        return sgn ? 64'($signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b})) : {32'b0, a} * {32'b0, b};
    endfunction

    // Radix-4 Booth recoding of b; negative rows are sent as one's complement plus a correction bit
    task automatic drive_pp(input logic [31:0] a, input logic [31:0] b, input bit sgn);
        logic [35:0] bz;
        longint av, v;
        int d;
        bz = sgn ? {{3{b[31]}}, b, 1'b0} : {3'b0, b, 1'b0};
        av = sgn ? longint'($signed(a)) : longint'({32'b0, a});
        ec = '0;
        for (int i = 0; i < 17; i++) begin
            d = -2 * int'(bz[2*i+2]) + int'(bz[2*i+1]) + int'(bz[2*i]);
            if (i == 16) pp16 = d != 0 ? a : 32'b0;
            else begin
                v = longint'(d) * av;
                if (d < 0) begin
                    pp[i] = 34'(v - 1);
                    ec[i] = 1'b1;
                end else pp[i] = 34'(v);
            end
        end
    endtask

    task automatic send(input logic [31:0] a, input logic [31:0] b, input bit sgn, input logic [63:0] want);
        @(negedge clk);
        drive_pp(a, b, sgn);
        In_Valid = 1;
        #1;
        for (int w = 0; w < 200 && !In_Ready; w++) begin
            @(negedge clk);
            #1;
        end
        if (!In_Ready) fail("accept_timeout");
        else begin
            exp_q.push_back(want);
            acc_q.push_back(cyc + 1);
        end
        @(negedge clk);
        In_Valid = 0;
    endtask

    always @(negedge clk) begin
        #2;
        if (Reset) ov_prev = 0;
        else begin
            if (Out_Valid && !ov_prev) begin
                if (acc_q.size() == 0) fail("unexpected_valid");
                else chk("latency", 64'(cyc - acc_q.pop_front()), 64'(LAT));
            end
            if (Out_Valid && Out_Ready) begin
                if (exp_q.size() == 0) fail("unexpected_product");
                else chk("product", Product, exp_q.pop_front());
            end
            ov_prev = Out_Valid;
        end
    end

    task automatic drain();
        for (int w = 0; w < 200 && exp_q.size() > 0; w++) @(negedge clk);
        if (exp_q.size() > 0) fail("drain_timeout");
        repeat (2) @(negedge clk);
    endtask

    initial begin
        logic [31:0] a, b;
        bit sg;
        foreach (pp[i]) pp[i] = '0;
        repeat (3) @(negedge clk);
        #3;
        chk("rst_in_ready", 64'(In_Ready), 64'(0));
        chk("rst_out_valid", 64'(Out_Valid), 64'(0));
        chk("rst_product", Product, 64'h0);
        chk("rst_busy", 64'(Busy), 64'(0));
        @(negedge clk);
        Reset = 0;
        #1;
        chk("post_rst_in_ready", 64'(In_Ready), 64'(1));

        send(32'hFFFFFFFF, 32'hFFFFFFFF, 0, 64'hFFFFFFFE00000001);
        send(32'hFFFFFFFF, 32'hFFFFFFFF, 1, 64'h0000000000000001);
        send(32'h80000000, 32'h80000000, 1, 64'h4000000000000000);
        drain();

        // backpressure: result must hold while the consumer stalls
        @(posedge clk);
        mode = 1;
        send(32'd7, 32'd9, 0, 64'd63);
        for (int w = 0; w < 20 && !Out_Valid; w++) @(negedge clk);
        @(negedge clk);
        #3;
        held = Product;
        chk("bp_value", held, 64'd63);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            #3;
            chk("bp_valid", 64'(Out_Valid), 64'(1));
            chk("bp_product", Product, held);
            chk("bp_in_ready", 64'(In_Ready), 64'(0));
        end
        @(posedge clk);
        mode = 0;
        @(negedge clk);
        @(negedge clk);
        #3;
        chk("bp_release_idle", 64'(Busy), 64'(0));
        chk("bp_release_ready", 64'(In_Ready), 64'(1));

        // reset during compression step 2 drops the transaction
        send(32'h12345678, 32'h9ABCDEF0, 0, ref_prod(32'h12345678, 32'h9ABCDEF0, 0));
        @(negedge clk);
        @(negedge clk);
        Reset = 1;
        exp_q.delete();
        acc_q.delete();
        @(negedge clk);
        Reset = 0;
        #3;
        chk("midrst_busy", 64'(Busy), 64'(0));
        chk("midrst_valid", 64'(Out_Valid), 64'(0));
        repeat (10) @(negedge clk);
        send(32'd3, 32'd5, 0, 64'd15);
        drain();

        // reset and a valid set on the same edge: nothing is captured
        @(negedge clk);
        drive_pp(32'd11, 32'd13, 0);
        Reset = 1;
        In_Valid = 1;
        #1;
        chk("rv_in_ready", 64'(In_Ready), 64'(0));
        @(negedge clk);
        Reset = 0;
        In_Valid = 0;
        #1;
        chk("rv_busy", 64'(Busy), 64'(0));
        repeat (10) @(negedge clk);
        chk("rv_no_output", 64'(Out_Valid), 64'(0));

        @(posedge clk);
        mode = 2;
        for (int n = 0; n < 400; n++) begin
            a = $urandom;
            b = $urandom;
            sg = 1'($urandom_range(1));
            case ($urandom_range(7))
                0: a = 32'hFFFFFFFF;
                1: b = 32'h80000000;
                2: a = 32'h0;
                default: ;
            endcase
            send(a, b, sg, ref_prod(a, b, sg));
        end
        @(posedge clk);
        mode = 0;
        drain();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
